mem_request_scheduler: RTL

//  Schedules NUM_PORTS core memory requesters (D$, I$, DMMU, IMMU) onto the single mem master port.

---
 rtl/mem_request_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_request_scheduler.sv
// Arbitrates core memory requesters onto the single mem master port.
// Round-robin with starvation aging, per-port read caps and a held grant.
module mem_request_scheduler #(
    parameter  int NUM_PORTS       = 4,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int AGE_LIMIT       = 15,
    localparam int ID_W            = $clog2(NUM_PORTS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
    localparam int AGE_W           = $clog2(AGE_LIMIT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       request,
    input  logic [NUM_PORTS-1:0]       rnw,
    output logic [NUM_PORTS-1:0]       port_ack,
    output logic                       mem_request,
    input  logic                       mem_ack,
    output logic [ID_W-1:0]            grant_port,
    output logic [ID_W-1:0]            mem_id,
    input  logic                       mem_rvalid,
    input  logic                       mem_rlast,
    input  logic [ID_W-1:0]            mem_rid,
    output logic [NUM_PORTS*CNT_W-1:0] outstanding,
    output logic                       err_underflow
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_lock;
    logic [ID_W-1:0]      r_rr;
    logic [CNT_W-1:0]     r_cnt [NUM_PORTS];
    logic [AGE_W-1:0]     r_age [NUM_PORTS];
    logic                 r_err;

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_urg;
    logic [NUM_PORTS-1:0] w_inc;
    logic [NUM_PORTS-1:0] w_dec;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_grant;
    logic [ID_W-1:0]      w_sel;
    logic                 w_found;
    logic                 w_req;
    logic                 w_acc;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_elig[i] = request[i] &
                        (~rnw[i] | (r_cnt[i] < CNT_W'(MAX_OUTSTANDING)));
            w_urg[i]  = w_elig[i] & (r_age[i] == AGE_W'(AGE_LIMIT));
        end
    end

    // Descending scans so the last hit (lowest index / nearest rr) wins.
    always_comb begin
        w_winner = r_rr;
        w_found  = 1'b0;
        w_sel    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_urg[k]) begin
                w_winner = ID_W'(k);
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                w_sel = ID_W'((int'(r_rr) + k) % NUM_PORTS);
                if (w_elig[w_sel]) begin
                    w_winner = w_sel;
                end
            end
        end
    end

    always_comb begin
        w_req       = 1'b0;
        w_grant     = '0;
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                w_req   = |w_elig;
                w_grant = w_winner;
                if (w_req && !mem_ack) begin
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                w_req   = request[r_lock];
                w_grant = r_lock;
                if (!w_req || mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Outputs read as zero while reset is held, even with requests up.
        if (!rst) begin
            w_req   = 1'b0;
            w_grant = '0;
        end
    end

    assign w_acc         = w_req & mem_ack;
    assign mem_request   = w_req;
    assign grant_port    = w_grant;
    assign mem_id        = w_grant;
    assign err_underflow = r_err;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_ack[i] = w_acc & (w_grant == ID_W'(i));
            w_inc[i]    = port_ack[i] & rnw[i];
            w_dec[i]    = mem_rvalid & mem_rlast & (mem_rid == ID_W'(i));
            outstanding[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_lock  <= '0;
            r_rr    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_LOCKED) begin
                r_lock <= w_winner;
            end
            if (w_acc) begin
                r_rr <= (w_grant == ID_W'(NUM_PORTS - 1)) ? '0
                                                           : w_grant + 1'b1;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!request[i] || port_ack[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_W'(AGE_LIMIT)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
                unique case ({w_inc[i], w_dec[i]})
                    2'b10: r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01: begin
                        if (r_cnt[i] == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                    end
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

endmodule
